sram_mem_ctrl: RTL and testbench

//  Bridges the picorv32 native memory interface (mem_valid/mem_ready, 32-bit words)
//  to the board's external asynchronous 512K x16 SRAM (ADR/DAT/RAMOE/RAMWE/RAMCS).

---
 rtl/sram_mem_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// picorv32 native bus to 512Kx16 async SRAM bridge.
// Words split into two halfword accesses; partial halfword writes use RMW.
module sram_mem_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [18:0] sram_adr,
  output logic [15:0] sram_dat_o,
  input  logic [15:0] sram_dat_i,
  output logic        sram_dat_oe,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_cs_n,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, RD, TURN, WSU, WLO, WHD, DONE
  } state_t;

  typedef struct packed {
    state_t st;
    logic   h;
  } nxt_t;

  state_t      state;
  logic        half;
  logic [3:0]  cnt;
  logic [17:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [15:0] rb;

  nxt_t        nx;
  logic [3:0]  cnt_n;
  logic [17:0] addr_c;
  logic [31:0] wdata_c;
  logic [3:0]  wstrb_c;
  logic [1:0]  s_n;
  logic [15:0] w_n;
  logic        last_w;
  logic        last_t;
  logic        phase_n;
  logic        unused;

  assign unused = ^{mem_instr, mem_addr[31:20], mem_addr[1:0]};

  // First phase of half h; halves with no strobes take no cycles.
  function automatic nxt_t start_half(
    input logic       h,
    input logic [3:0] ws
  );
    nxt_t r;
    r.st = DONE;
    r.h  = 1'b1;
    if (ws == 4'b0000) begin
      r.st = RD;
      r.h  = 1'b0;
    end else if (!h && ws[1:0] == 2'b11) begin
      r.st = WSU;
      r.h  = 1'b0;
    end else if (!h && ws[1:0] != 2'b00) begin
      r.st = RD;
      r.h  = 1'b0;
    end else if (ws[3:2] == 2'b11) begin
      r.st = WSU;
    end else if (ws[3:2] != 2'b00) begin
      r.st = RD;
    end
    return r;
  endfunction

  function automatic logic [15:0] merge(
    input logic [15:0] w,
    input logic [15:0] old,
    input logic [1:0]  s
  );
    return {s[1] ? w[15:8] : old[15:8],
            s[0] ? w[7:0]  : old[7:0]};
  endfunction

  assign addr_c  = (state == IDLE) ? mem_addr[19:2] : addr_q;
  assign wdata_c = (state == IDLE) ? mem_wdata : wdata_q;
  assign wstrb_c = (state == IDLE) ? mem_wstrb : wstrb_q;
  assign last_w  = (cnt == 4'(WAIT_CYCLES - 1));
  assign last_t  = (cnt == 4'(TURN_CYCLES - 1));

  always_comb begin
    nx.st = state;
    nx.h  = half;
    cnt_n = cnt + 4'd1;
    unique case (state)
      IDLE: begin
        cnt_n = 4'd0;
        if (mem_valid) nx = start_half(1'b0, mem_wstrb);
      end
      RD: begin
        if (last_w) begin
          cnt_n = 4'd0;
          if (wstrb_q != 4'b0000) nx.st = TURN;
          else if (half) nx.st = DONE;
          else nx.h = 1'b1;
        end
      end
      TURN: begin
        if (last_t) begin
          cnt_n = 4'd0;
          nx.st = WSU;
        end
      end
      WSU: begin
        cnt_n = 4'd0;
        nx.st = WLO;
      end
      WLO: begin
        if (last_w) begin
          cnt_n = 4'd0;
          nx.st = WHD;
        end
      end
      WHD: begin
        cnt_n = 4'd0;
        if (half) nx.st = DONE;
        else nx = start_half(1'b1, wstrb_q);
      end
      DONE: begin
        cnt_n = 4'd0;
        nx.st = IDLE;
      end
      default: begin
        cnt_n = 4'd0;
        nx.st = IDLE;
      end
    endcase
  end

  assign phase_n = nx.st inside {RD, TURN, WSU, WLO, WHD};
  assign s_n = nx.h ? wstrb_c[3:2] : wstrb_c[1:0];
  assign w_n = nx.h ? wdata_c[31:16] : wdata_c[15:0];

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      half        <= 1'b0;
      cnt         <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rb          <= '0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      sram_adr    <= '0;
      sram_dat_o  <= '0;
      sram_dat_oe <= 1'b0;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_cs_n   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= nx.st;
      half        <= nx.h;
      cnt         <= cnt_n;
      mem_ready   <= (nx.st == DONE);
      busy        <= (nx.st != IDLE);
      sram_cs_n   <= !phase_n;
      sram_oe_n   <= (nx.st != RD);
      sram_we_n   <= (nx.st != WLO);
      sram_dat_oe <= nx.st inside {WSU, WLO, WHD};
      if (state == IDLE && mem_valid) begin
        addr_q  <= mem_addr[19:2];
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
      if (phase_n) sram_adr <= {addr_c, nx.h};
      if (nx.st == WSU) sram_dat_o <= merge(w_n, rb, s_n);
      if (state == RD && last_w) begin
        if (wstrb_q == 4'b0000 && half)
          mem_rdata <= {sram_dat_i, rb};
        else
          rb <= sram_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed-vector bench for sram_mem_ctrl with a behavioural async SRAM.
// Vectors carry hand-computed latency, read data and strobe counts.
module tb_sram_mem_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [18:0] sram_adr;
  logic [15:0] sram_dat_o;
  logic [15:0] sram_dat_i;
  logic        sram_dat_oe;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_cs_n;
  logic        busy;

  sram_mem_ctrl #(.WAIT_CYCLES(2), .TURN_CYCLES(1)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .sram_adr(sram_adr),
    .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i),
    .sram_dat_oe(sram_dat_oe), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_cs_n(sram_cs_n),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [15:0] sram [0:1023];
  int touch [1024];
  int we_cnt = 0;
  int oe_cnt = 0;
  int viol = 0;
  int n_chk = 0;
  int n_pass = 0;

  assign sram_dat_i = sram_oe_n ? 16'h0000 : sram[sram_adr[9:0]];

  always @(posedge clk)
    if (!sram_we_n && !sram_cs_n) sram[sram_adr[9:0]] = sram_dat_o;

  always @(negedge clk) begin
    if (!sram_we_n) we_cnt++;
    if (!sram_oe_n) oe_cnt++;
    if (!sram_cs_n) touch[sram_adr[9:0]]++;
    if ((!sram_oe_n && !sram_we_n) || (!sram_oe_n && sram_dat_oe) ||
        (!sram_we_n && !sram_dat_oe))
      viol++;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
    int          we;
    int          oe;
    int          nt;
  } vec_t;

  // Caller is at a negedge with the DUT in IDLE.
  task automatic run_row(input vec_t r, input bit hold);
    int w0, o0, t0, cyc;
    w0 = we_cnt;
    o0 = oe_cnt;
    t0 = touch[r.nt];
    cyc = 0;
    mem_valid = 1'b1;
    mem_instr = r.instr;
    mem_addr  = r.addr;
    mem_wdata = r.wdata;
    mem_wstrb = r.wstrb;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) chk({r.name, " busy"}, 32'(busy), 32'd1);
      if (c == 2) begin
        mem_wdata = ~r.wdata;
        mem_wstrb = ~r.wstrb;
        mem_addr  = r.addr ^ 32'h8;
      end
      if (mem_ready) begin
        cyc = c;
        break;
      end
    end
    if (!hold) mem_valid = 1'b0;
    chk({r.name, " latency"}, 32'(cyc), 32'(r.lat));
    chk({r.name, " rdata"}, mem_rdata, r.rdata);
    @(negedge clk);
    chk({r.name, " ready_pulse"}, 32'(mem_ready), 32'd0);
    chk({r.name, " we_cycles"}, 32'(we_cnt - w0), 32'(r.we));
    chk({r.name, " oe_cycles"}, 32'(oe_cnt - o0), 32'(r.oe));
    chk({r.name, " untouched"}, 32'(touch[r.nt] - t0), 32'd0);
  endtask

  vec_t rows [8];
  vec_t b2b [2];

  initial begin
    resetn = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    for (int i = 0; i < 1024; i++) sram[i] = 16'h0000;
    sram[10'h20] = 16'hBEEF;
    sram[10'h21] = 16'hDEAD;
    sram[10'h22] = 16'h1111;
    sram[10'h23] = 16'h2222;

    rows[0] = '{"rd40", 1'b0, 32'h40, 32'h0, 4'h0, 5,
                32'hDEADBEEF, 0, 4, 1023};
    rows[1] = '{"wr_full", 1'b0, 32'h44, 32'h12345678, 4'hF, 9,
                32'hDEADBEEF, 4, 0, 1023};
    rows[2] = '{"rmw_lo", 1'b0, 32'h40, 32'h0000AB00, 4'h2, 8,
                32'hDEADBEEF, 2, 2, 10'h21};
    rows[3] = '{"wr_hi", 1'b0, 32'h40, 32'hCAFE0000, 4'hC, 5,
                32'hDEADBEEF, 2, 0, 10'h20};
    rows[4] = '{"rmw_hi", 1'b0, 32'h44, 32'h00990000, 4'h4, 8,
                32'hDEADBEEF, 2, 2, 10'h22};
    rows[5] = '{"wr_mix", 1'b0, 32'h44, 32'hAA11BB22, 4'h7, 12,
                32'hDEADBEEF, 4, 2, 1023};
    rows[6] = '{"rd44", 1'b0, 32'h44, 32'h0, 4'h0, 5,
                32'h1211BB22, 0, 4, 1023};
    rows[7] = '{"rd_hiaddr", 1'b0, 32'hFFF00042, 32'h0, 4'h0, 5,
                32'hCAFEABEF, 0, 4, 1023};

    b2b[0] = '{"fetch", 1'b1, 32'h44, 32'h5A5A5A5A, 4'h0, 5,
               32'h1211BB22, 0, 4, 1023};
    b2b[1] = '{"rd_b2b", 1'b0, 32'h40, 32'hA5A5A5A5, 4'h0, 5,
               32'hDEADBEEF, 0, 4, 1023};

    #23;
    chk("rst cs_n", 32'(sram_cs_n), 32'd1);
    chk("rst oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst we_n", 32'(sram_we_n), 32'd1);
    chk("rst dat_oe", 32'(sram_dat_oe), 32'd0);
    chk("rst ready", 32'(mem_ready), 32'd0);
    chk("rst rdata", mem_rdata, 32'd0);
    chk("rst adr", 32'(sram_adr), 32'd0);
    chk("rst dat_o", 32'(sram_dat_o), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_row(rows[i], 1'b0);
      if (i == 1) begin
        chk("mem 22", 32'(sram[10'h22]), 32'h5678);
        chk("mem 23", 32'(sram[10'h23]), 32'h1234);
      end
    end
    chk("mem 20", 32'(sram[10'h20]), 32'hABEF);
    chk("mem 21", 32'(sram[10'h21]), 32'hCAFE);
    chk("mem 22 mix", 32'(sram[10'h22]), 32'hBB22);
    chk("mem 23 mix", 32'(sram[10'h23]), 32'h1211);

    // Reset asserted while we_n is low must drop strobes immediately.
    sram[10'h20] = 16'hBEEF;
    sram[10'h21] = 16'hDEAD;
    mem_valid = 1'b1;
    mem_addr  = 32'h48;
    mem_wdata = 32'h01020304;
    mem_wstrb = 4'hF;
    begin
      int seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (!sram_we_n) begin
          seen = 1;
          break;
        end
      end
      chk("mid_rst we_low_seen", 32'(seen), 32'd1);
    end
    resetn = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("mid_rst we_n", 32'(sram_we_n), 32'd1);
    chk("mid_rst cs_n", 32'(sram_cs_n), 32'd1);
    chk("mid_rst dat_oe", 32'(sram_dat_oe), 32'd0);
    chk("mid_rst ready", 32'(mem_ready), 32'd0);
    chk("mid_rst busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_row(rows[0], 1'b0);

    run_row(b2b[0], 1'b1);
    run_row(b2b[1], 1'b0);

    chk("strobe overlap", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
